// File: rtl/reg_file_param.sv
// Parameterised two-read/one-write register file with a busy-bit scoreboard and a debug read port.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file_param #(
    parameter int DW          = 32,
    parameter int AW          = 5,
    parameter int DBG_DEFAULT = 19
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic [AW-1:0] rR1_i,
    input  logic [AW-1:0] rR2_i,
    output logic [DW-1:0] rD1_o,
    output logic [DW-1:0] rD2_o,
    input  logic [AW-1:0] wR_i,
    input  logic [DW-1:0] wD_i,
    input  logic          WE_i,
    input  logic          alloc_i,
    input  logic [AW-1:0] alloc_rd_i,
    output logic          busy1_o,
    output logic          busy2_o,
    input  logic          dbg_sel_i,
    input  logic [AW-1:0] dbg_addr_i,
    output logic [DW-1:0] dbg_data_o,
    output logic          ready_o
);

    localparam int NREG = 2**AW;

    typedef enum logic [0:0] {
        WAIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_r;
    state_t          nextState_s;
    logic [DW-1:0]   regFile_r [NREG];
    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] busyNext_s;
    logic [AW-1:0]   dbgPtr_r;
    logic            writeCommit_s;
    logic            allocCommit_s;

    // FSM state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= WAIT;
        end else begin
            state_r <= nextState_s;
        end
    end

    // FSM next state: WAIT lasts exactly one edge after reset release
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            WAIT:    nextState_s = RUN;
            RUN:     nextState_s = RUN;
            default: nextState_s = WAIT;
        endcase
    end

    assign ready_o = (state_r == RUN);

    // Commit qualifiers; register 0 is never written or allocated
    always_comb begin
        writeCommit_s = WE_i    && ready_o && (wR_i       != {AW{1'b0}});
        allocCommit_s = alloc_i && ready_o && (alloc_rd_i != {AW{1'b0}});
    end

    // Register storage
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int r = 0; r < NREG; r++) begin
                regFile_r[r] <= {DW{1'b0}};
            end
        end else if (writeCommit_s) begin
            regFile_r[wR_i] <= wD_i;
        end else begin
            regFile_r[wR_i] <= regFile_r[wR_i];
        end
    end

    // Scoreboard next state: allocation wins over a same-edge write clear
    always_comb begin
        busyNext_s = busy_r;
        for (int r = 0; r < NREG; r++) begin
            if (allocCommit_s && (alloc_rd_i == AW'(r))) begin
                busyNext_s[r] = 1'b1;
            end else if (writeCommit_s && (wR_i == AW'(r))) begin
                busyNext_s[r] = 1'b0;
            end else begin
                busyNext_s[r] = busy_r[r];
            end
        end
        busyNext_s[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busyNext_s;
        end
    end

    // Debug pointer
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            dbgPtr_r <= AW'(DBG_DEFAULT);
        end else if (dbg_sel_i) begin
            dbgPtr_r <= dbg_addr_i;
        end else begin
            dbgPtr_r <= dbgPtr_r;
        end
    end

    assign dbg_data_o = regFile_r[dbgPtr_r];

    // Read ports; a forwarded register reports the scoreboard value it will hold after this edge
    always_comb begin
        rD1_o   = regFile_r[rR1_i];
        rD2_o   = regFile_r[rR2_i];
        busy1_o = busy_r[rR1_i];
        busy2_o = busy_r[rR2_i];
`ifdef REGFILE_BYPASS_EN
        if (writeCommit_s && (wR_i == rR1_i)) begin
            rD1_o   = wD_i;
            busy1_o = allocCommit_s && (alloc_rd_i == rR1_i);
        end else begin
            rD1_o   = regFile_r[rR1_i];
            busy1_o = busy_r[rR1_i];
        end
        if (writeCommit_s && (wR_i == rR2_i)) begin
            rD2_o   = wD_i;
            busy2_o = allocCommit_s && (alloc_rd_i == rR2_i);
        end else begin
            rD2_o   = regFile_r[rR2_i];
            busy2_o = busy_r[rR2_i];
        end
`else
        rD1_o   = regFile_r[rR1_i];
        rD2_o   = regFile_r[rR2_i];
        busy1_o = busy_r[rR1_i];
        busy2_o = busy_r[rR2_i];
`endif
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed self-checking bench for reg_file_param; expectations follow REGFILE_BYPASS_EN when defined.
module tb_reg_file_param;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [AW-1:0] rR1_i, rR2_i, wR_i, alloc_rd_i, dbg_addr_i;
    logic [DW-1:0] rD1_o, rD2_o, wD_i, dbg_data_o;
    logic          WE_i, alloc_i, dbg_sel_i;
    logic          busy1_o, busy2_o, ready_o;

    int vecCount  = 0;
    int missCount = 0;

    reg_file_param #(.DW(DW), .AW(AW), .DBG_DEFAULT(19)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .rR1_i(rR1_i), .rR2_i(rR2_i), .rD1_o(rD1_o), .rD2_o(rD2_o),
        .wR_i(wR_i), .wD_i(wD_i), .WE_i(WE_i),
        .alloc_i(alloc_i), .alloc_rd_i(alloc_rd_i),
        .busy1_o(busy1_o), .busy2_o(busy2_o),
        .dbg_sel_i(dbg_sel_i), .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o),
        .ready_o(ready_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        tick();
        vecCount++; if (ready_o !== 1'b0) begin missCount++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        vecCount++; if (rD1_o !== 32'h0) begin missCount++; $display("FAIL reset_rd1: got %h want 0", rD1_o); end
        vecCount++; if (dbg_data_o !== 32'h0) begin missCount++; $display("FAIL reset_dbg: got %h want 0", dbg_data_o); end
        vecCount++; if ({busy1_o, busy2_o} !== 2'b00) begin missCount++; $display("FAIL reset_busy: got %b want 00", {busy1_o, busy2_o}); end
    endtask

    task automatic test_wait_drop;
        reset_i = 1'b0;
        WE_i = 1'b1; wR_i = 5'd3; wD_i = 32'hAAAA5555; rR1_i = 5'd3;
        #1;
        vecCount++; if (ready_o !== 1'b0) begin missCount++; $display("FAIL wait_ready: got %b want 0", ready_o); end
        tick();
        WE_i = 1'b0;
        #1;
        vecCount++; if (ready_o !== 1'b1) begin missCount++; $display("FAIL run_ready: got %b want 1", ready_o); end
        vecCount++; if (rD1_o !== 32'h0) begin missCount++; $display("FAIL wait_drop: got %h want 0", rD1_o); end
    endtask

    task automatic test_write;
        WE_i = 1'b1; wR_i = 5'd31; wD_i = 32'h12345678; tick();
        wR_i = 5'd0; wD_i = 32'hFFFFFFFF; tick();
        wR_i = 5'd19; wD_i = 32'h19191919; tick();
        WE_i = 1'b0; rR1_i = 5'd31; rR2_i = 5'd0;
        #1;
        vecCount++; if (rD1_o !== 32'h12345678) begin missCount++; $display("FAIL write_r31: got %h want 12345678", rD1_o); end
        vecCount++; if (rD2_o !== 32'h0) begin missCount++; $display("FAIL write_r0: got %h want 0", rD2_o); end
        vecCount++; if (dbg_data_o !== 32'h19191919) begin missCount++; $display("FAIL dbg_default: got %h want 19191919", dbg_data_o); end
    endtask

    task automatic test_scoreboard;
        rR1_i = 5'd7; rR2_i = 5'd0;
        alloc_i = 1'b1; alloc_rd_i = 5'd7; tick();
        alloc_rd_i = 5'd0; tick();
        alloc_i = 1'b0;
        #1;
        vecCount++; if (busy1_o !== 1'b1) begin missCount++; $display("FAIL busy_c1: got %b want 1", busy1_o); end
        vecCount++; if (busy2_o !== 1'b0) begin missCount++; $display("FAIL busy_r0: got %b want 0", busy2_o); end
        WE_i = 1'b1; wR_i = 5'd7; wD_i = 32'h0707CAFE;
        #1;
`ifdef REGFILE_BYPASS_EN
        vecCount++; if (busy1_o !== 1'b0) begin missCount++; $display("FAIL busy_c2: got %b want 0", busy1_o); end
`else
        vecCount++; if (busy1_o !== 1'b1) begin missCount++; $display("FAIL busy_c2: got %b want 1", busy1_o); end
`endif
        tick();
        WE_i = 1'b0;
        #1;
        vecCount++; if (busy1_o !== 1'b0) begin missCount++; $display("FAIL busy_clear: got %b want 0", busy1_o); end
        vecCount++; if (rD1_o !== 32'h0707CAFE) begin missCount++; $display("FAIL sb_data: got %h want 0707cafe", rD1_o); end
    endtask

    task automatic test_same_edge;
        rR1_i = 5'd5;
        WE_i = 1'b1; wR_i = 5'd5; wD_i = 32'h55550005;
        alloc_i = 1'b1; alloc_rd_i = 5'd5;
        tick();
        WE_i = 1'b0;
        #1;
        vecCount++; if (busy1_o !== 1'b1) begin missCount++; $display("FAIL same_busy: got %b want 1", busy1_o); end
        vecCount++; if (rD1_o !== 32'h55550005) begin missCount++; $display("FAIL same_data: got %h want 55550005", rD1_o); end
        tick();
        alloc_i = 1'b0;
        WE_i = 1'b1; wR_i = 5'd5; wD_i = 32'h55550006;
        tick();
        WE_i = 1'b0;
        #1;
        vecCount++; if (busy1_o !== 1'b0) begin missCount++; $display("FAIL realloc_clear: got %b want 0", busy1_o); end
    endtask

    task automatic test_bypass;
        WE_i = 1'b1; wR_i = 5'd9; wD_i = 32'h11119999;
        alloc_i = 1'b1; alloc_rd_i = 5'd9;
        tick();
        WE_i = 1'b0; alloc_i = 1'b0;
        rR2_i = 5'd9;
        WE_i = 1'b1; wR_i = 5'd9; wD_i = 32'hDEADBEEF;
        #1;
`ifdef REGFILE_BYPASS_EN
        vecCount++; if (rD2_o !== 32'hDEADBEEF) begin missCount++; $display("FAIL byp_same: got %h want deadbeef", rD2_o); end
        vecCount++; if (busy2_o !== 1'b0) begin missCount++; $display("FAIL byp_busy: got %b want 0", busy2_o); end
`else
        vecCount++; if (rD2_o !== 32'h11119999) begin missCount++; $display("FAIL byp_same: got %h want 11119999", rD2_o); end
        vecCount++; if (busy2_o !== 1'b1) begin missCount++; $display("FAIL byp_busy: got %b want 1", busy2_o); end
`endif
        tick();
        WE_i = 1'b0;
        #1;
        vecCount++; if (rD2_o !== 32'hDEADBEEF) begin missCount++; $display("FAIL byp_next: got %h want deadbeef", rD2_o); end
        vecCount++; if (busy2_o !== 1'b0) begin missCount++; $display("FAIL byp_busy_next: got %b want 0", busy2_o); end
    endtask

    task automatic test_reset_mid;
        dbg_sel_i = 1'b1; dbg_addr_i = 5'd4; tick();
        dbg_sel_i = 1'b0;
        WE_i = 1'b1; wR_i = 5'd4; wD_i = 32'h44444444; tick();
        WE_i = 1'b0;
        #1;
        vecCount++; if (dbg_data_o !== 32'h44444444) begin missCount++; $display("FAIL dbg_ptr4: got %h want 44444444", dbg_data_o); end
        alloc_i = 1'b1; alloc_rd_i = 5'd12; tick();
        alloc_i = 1'b0; rR1_i = 5'd31; rR2_i = 5'd12;
        #1;
        vecCount++; if (busy2_o !== 1'b1) begin missCount++; $display("FAIL pre_busy12: got %b want 1", busy2_o); end
        WE_i = 1'b1; wR_i = 5'd12; wD_i = 32'hCCCCCCCC;
        alloc_i = 1'b1; alloc_rd_i = 5'd20;
        reset_i = 1'b1;
        #1;
        vecCount++; if (rD1_o !== 32'h0) begin missCount++; $display("FAIL mid_rd1: got %h want 0", rD1_o); end
        vecCount++; if (busy2_o !== 1'b0) begin missCount++; $display("FAIL mid_busy: got %b want 0", busy2_o); end
        vecCount++; if (ready_o !== 1'b0) begin missCount++; $display("FAIL mid_ready: got %b want 0", ready_o); end
        vecCount++; if (dbg_data_o !== 32'h0) begin missCount++; $display("FAIL mid_dbg: got %h want 0", dbg_data_o); end
        tick();
        WE_i = 1'b0; alloc_i = 1'b0;
        reset_i = 1'b0;
        rR1_i = 5'd20; rR2_i = 5'd12;
        #1;
        vecCount++; if (ready_o !== 1'b0) begin missCount++; $display("FAIL rel_ready: got %b want 0", ready_o); end
        vecCount++; if (rD2_o !== 32'h0) begin missCount++; $display("FAIL rel_r12: got %h want 0", rD2_o); end
        vecCount++; if (busy1_o !== 1'b0) begin missCount++; $display("FAIL rel_busy20: got %b want 0", busy1_o); end
        tick();
        vecCount++; if (ready_o !== 1'b1) begin missCount++; $display("FAIL rel_run: got %b want 1", ready_o); end
        WE_i = 1'b1; wR_i = 5'd19; wD_i = 32'h19CAFE19; tick();
        WE_i = 1'b0;
        #1;
        vecCount++; if (dbg_data_o !== 32'h19CAFE19) begin missCount++; $display("FAIL dbg_ptr_reset: got %h want 19cafe19", dbg_data_o); end
    endtask

    initial begin
        reset_i = 1'b1;
        rR1_i = 5'd0; rR2_i = 5'd0; wR_i = 5'd0; wD_i = 32'h0; WE_i = 1'b0;
        alloc_i = 1'b0; alloc_rd_i = 5'd0; dbg_sel_i = 1'b0; dbg_addr_i = 5'd0;
        test_reset();
        test_wait_drop();
        test_write();
        test_scoreboard();
        test_same_edge();
        test_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 The block SHALL have parameter DW, default 32, giving the data width in bits.
REQ-002 The block SHALL have parameter AW, default 5, giving the register address width; NREG = 2**AW registers.
REQ-003 The block SHALL have parameter DBG_DEFAULT, default 19, giving the register index shown on dbg_data_o after reset.
REQ-004 Port clk_i  input  1  system clock, rising-edge active.
REQ-005 Port reset_i  input  1  asynchronous, active-high reset.
REQ-006 Port rR1_i / rR2_i  input  AW  read addresses, ports 1 and 2.
REQ-007 Port rD1_o / rD2_o  output  DW  read data, ports 1 and 2.
REQ-008 Port wR_i  input  AW  write address.
REQ-009 Port wD_i  input  DW  write data.
REQ-010 Port WE_i  input  1  write enable.
REQ-011 Port alloc_i  input  1  scoreboard allocate strobe.
REQ-012 Port alloc_rd_i  input  AW  register being allocated.
REQ-013 Port busy1_o / busy2_o  output  1  pending-write flag for rR1_i / rR2_i.
REQ-014 Port dbg_sel_i  input  1  on high, load dbg_addr_i into the debug pointer.
REQ-015 Port dbg_addr_i  input  AW  debug register index.
REQ-016 Port dbg_data_o  output  DW  contents of the debug-selected register.
REQ-017 Port ready_o  output  1  block accepts writes and allocations.

Function
REQ-018 Register 0 SHALL read as 0, ignore writes and never be busy.
REQ-019 Reads SHALL be combinational, with zero cycles of latency from rR*_i to rD*_o; while reset_i is high, rD1_o, rD2_o and dbg_data_o SHALL be 0.
REQ-020 A write SHALL commit at the rising edge when WE_i=1, ready_o=1 and wR_i!=0; the new value is visible to non-bypassed reads on the next cycle.
REQ-021 The FSM SHALL have two states: WAIT (entered on reset; ready_o=0; writes and allocations dropped) and RUN (ready_o=1).
REQ-022 The FSM SHALL move WAIT -> RUN on the first rising edge after reset_i falls, and SHALL stay in RUN until the next reset.
REQ-023 The scoreboard SHALL hold one busy bit per register; the bit for alloc_rd_i SHALL be set at the edge when alloc_i=1, ready_o=1 and alloc_rd_i!=0.
REQ-024 A committed write to register r SHALL clear busy[r], unless the same edge also allocates r, in which case busy[r] SHALL stay 1.
REQ-025 Allocating a register that is already busy SHALL leave it busy; no counting takes place.
REQ-026 busy1_o / busy2_o SHALL equal busy[rR1_i] / busy[rR2_i], subject to REQ-032.
REQ-027 The debug pointer SHALL load dbg_addr_i at the edge when dbg_sel_i=1; dbg_data_o SHALL combinationally show the pointed register, with no bypass.
REQ-028 A reset asserted mid-operation SHALL abort any write or allocation on that edge.

Reset
REQ-029 On reset_i=1, immediately and without a clock: all registers 0, all busy bits 0, FSM=WAIT, ready_o=0, debug pointer=DBG_DEFAULT, busy1_o=busy2_o=0.

Configuration
REQ-030 The macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-031 When REGFILE_BYPASS_EN is defined and a write commits this cycle with wR_i==rRn_i!=0, rDn_o SHALL return wD_i in the same cycle.
REQ-032 In the same case, busyn_o SHALL be 0, unless that register is also being allocated this cycle.
REQ-033 When REGFILE_BYPASS_EN is not defined, rDn_o SHALL return the stored value and busyn_o SHALL return the registered busy bit.

Verification
REQ-034 Release reset; in the first cycle drive WE_i=1, wR_i=3, wD_i=0xAAAA5555 -> no write occurs (ready_o=0) and a read of register 3 returns 0 in the next cycle.
REQ-035 In RUN, write 0x12345678 to register 31 and 0xFFFFFFFF to register 0 -> register 31 reads 0x12345678; register 0 reads 0.
REQ-036 Allocate register 7, then write register 7 two cycles later with rR1_i=7 -> busy1_o=1 for 2 cycles, then 0; rD1_o=written value.
REQ-037 On the same edge, write register 5 and allocate register 5 -> busy[5] remains 1 and register 5 holds the new data.
REQ-038 With REGFILE_BYPASS_EN defined, set rR2_i=9 and commit a write of 0xDEADBEEF to register 9 -> rD2_o=0xDEADBEEF in the same cycle; without the macro, the old value that cycle and 0xDEADBEEF the next cycle.
REQ-039 Assert reset mid-run, with registers and busy bits set and the debug pointer at 4 -> all reads return 0, busy bits are 0, dbg_data_o shows register 19, and ready_o=0 until one edge after release.
